// File: rtl/capture_ctrl.sv
// ============================================================================
// capture_ctrl : sequences one pre/post-trigger capture into a circular RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stop,
  input  logic              clr_done,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W:0]   C_ENTRIES = (ADDR_W+1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(ENTRIES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] start_q, start_d;

  logic [ADDR_W-1:0] w_tp_clamped;
  logic [ADDR_W-1:0] w_waddr_inc;
  logic [ADDR_W:0]   w_pre_inc;
  logic [ADDR_W:0]   w_post_inc;
  logic [ADDR_W:0]   w_arm_cnt;

  // Post-trigger length must leave at least one pre-trigger slot and be non-zero.
  always_comb begin
    if (trig_pos == '0)
      w_tp_clamped = ADDR_W'(1);
    else if ({1'b0, trig_pos} >= C_ENTRIES)
      w_tp_clamped = C_LAST;
    else
      w_tp_clamped = trig_pos;
  end

  assign w_waddr_inc = (waddr_q == C_LAST) ? '0 : waddr_q + 1'b1;
  assign w_pre_inc   = pre_cnt_q + 1'b1;
  assign w_post_inc  = post_cnt_q + 1'b1;
  assign w_arm_cnt   = C_ENTRIES - {1'b0, tp_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      tp_q       <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      tp_q       <= tp_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      start_q    <= start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    tp_d       = tp_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d    = S_PREFILL;
          waddr_d    = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          tp_d       = w_tp_clamped;
        end else if (clr_done && state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_PREFILL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (wrt_smpl) begin
          waddr_d   = w_waddr_inc;
          pre_cnt_d = w_pre_inc;
          if (w_pre_inc == w_arm_cnt)
            state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (wrt_smpl) begin
          waddr_d = w_waddr_inc;
          if (triggered) begin
            post_cnt_d = (ADDR_W+1)'(1);
            state_d    = (tp_q == ADDR_W'(1)) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (wrt_smpl) begin
          waddr_d    = w_waddr_inc;
          post_cnt_d = w_post_inc;
          if (w_post_inc == {1'b0, tp_q})
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; start_addr captures the slot after the final write (oldest sample).
  always_comb begin
    we      = wrt_smpl & ((state_q == S_PREFILL) || (state_q == S_ARMED) ||
                          (state_q == S_POST));
    armed_d = (state_d == S_ARMED);
    done_d  = (state_d == S_DONE);
    start_d = (state_d == S_DONE) ? waddr_d : start_q;
  end

  assign waddr        = waddr_q;
  assign armed        = armed_q;
  assign capture_done = done_q;
  assign start_addr   = start_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_ctrl.sv
// ============================================================================
// tb_capture_ctrl : directed + random checks of capture_ctrl against a
// write-count reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_capture_ctrl;

  localparam int E = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, run, stop, clr_done, wrt_smpl, triggered;
  logic [AW-1:0] trig_pos;
  logic          we, armed, capture_done;
  logic [AW-1:0] waddr, start_addr;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, we_cnt = 0;

  // Reference model: a capture is described by the number of writes since run,
  // the write index that carried the accepted trigger, and the clamped length.
  bit m_active, m_done;
  int m_n, m_kt, m_tp, m_waddr, m_start;

  capture_ctrl #(.ENTRIES(E), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .clr_done(clr_done),
    .wrt_smpl(wrt_smpl), .triggered(triggered), .trig_pos(trig_pos),
    .we(we), .waddr(waddr), .armed(armed), .capture_done(capture_done),
    .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  function automatic int clamp_tp(input int tp);
    if (tp == 0) return 1;
    if (tp >= E) return E - 1;
    return tp;
  endfunction

  function automatic bit m_armed();
    return m_active && (m_kt == 0) && (m_n >= E - m_tp);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_n = 0; m_kt = 0; m_tp = 0; m_waddr = 0; m_start = 0;
  endtask

  task automatic model_step();
    if (m_active) begin
      if (stop) begin
        m_active = 0;
      end else if (wrt_smpl) begin
        m_n++;
        m_waddr = (m_waddr + 1) % E;
        if (m_kt == 0 && m_n > E - m_tp && triggered) m_kt = m_n;
        if (m_kt != 0 && m_n == m_kt + m_tp - 1) begin
          m_active = 0;
          m_done   = 1;
          m_start  = m_waddr;
        end
      end
    end else if (run) begin
      m_active = 1; m_done = 0; m_n = 0; m_kt = 0; m_waddr = 0;
      m_tp = clamp_tp(int'(trig_pos));
    end else if (m_done && clr_done) begin
      m_done = 0;
    end
  endtask

  task automatic check_outputs();
    chk("armed", armed, m_armed());
    chk("capture_done", capture_done, m_done);
    if (m_active || m_done) chk("waddr", waddr, m_waddr);
    if (m_done) chk("start_addr", start_addr, m_start);
  endtask

  // One clock: drive inputs, check comb we mid-cycle, advance model, check registers.
  task automatic tick(input logic r, input logic s, input logic c, input logic t);
    run = r; stop = s; clr_done = c; triggered = t;
    wrt_smpl = (cyc % 4 == 3);
    @(negedge clk);
    chk("we", we, m_active && wrt_smpl);
    if (we) we_cnt++;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_outputs();
    run = 0; stop = 0; clr_done = 0;
  endtask

  // Start a capture and run until done; trigger is held high from write trig_from on.
  task automatic capture(input logic [AW-1:0] tp, input int trig_from);
    trig_pos = tp;
    we_cnt = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 400 && !m_done; i++) tick(0, 0, 0, (m_n + 1) >= trig_from);
    chk("done_reached", capture_done, 1);
  endtask

  initial begin
    rst_n = 0; run = 0; stop = 0; clr_done = 0; wrt_smpl = 0; triggered = 0;
    trig_pos = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", capture_done, 0);
    rst_n = 1;

    // Scenario 1: tp=4, trigger from sample 20
    capture(5'd4, 20);
    chk("s1_start", start_addr, 7);
    chk("s1_we_cnt", we_cnt, 23);

    // Scenario 2: tp=0 clamps to 1, trigger always present
    tick(0, 0, 1, 0);
    chk("s2_clr", capture_done, 0);
    capture(5'd0, 1);
    chk("s2_start", start_addr, 0);
    chk("s2_we_cnt", we_cnt, 16);

    // Scenario 3: tp=20 clamps to 15, run straight out of DONE
    capture(5'd20, 1);
    chk("s3_start", start_addr, 0);
    chk("s3_we_cnt", we_cnt, 16);

    // Scenario 5a: DONE ignores strobes, clr_done returns to IDLE
    we_cnt = 0;
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 1);
    chk("s5_done_no_we", we_cnt, 0);
    chk("s5_waddr_frozen", waddr, 0);
    tick(0, 0, 1, 0);
    chk("s5_clr", capture_done, 0);

    // Scenario 4: stop while armed
    trig_pos = 5'd4;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 200 && m_n < 14; i++) tick(0, 0, 0, 0);
    chk("s4_armed", armed, 1);
    tick(0, 1, 0, 0);
    chk("s4_stop_armed", armed, 0);
    chk("s4_stop_done", capture_done, 0);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1);
    chk("s4_idle_no_we", we_cnt, 0);
    trig_pos = 5'd4;
    tick(1, 0, 0, 0);
    chk("s4_restart_waddr", waddr, 0);
    tick(0, 1, 0, 0);

    // Scenario 5b: run+stop together in POST -> IDLE
    trig_pos = 5'd8;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 200 && m_kt == 0; i++) tick(0, 0, 0, (m_n + 1) >= 13);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("s5_runstop_done", capture_done, 0);
    chk("s5_runstop_armed", armed, 0);
    we_cnt = 0;
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0);
    chk("s5_runstop_no_we", we_cnt, 0);

    // Scenario 6: asynchronous reset during POST
    trig_pos = 5'd8;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 200 && m_kt == 0; i++) tick(0, 0, 0, (m_n + 1) >= 10);
    chk("s6_in_post", (m_active && m_kt != 0), 1);
    #2;
    rst_n = 0;
    wrt_smpl = 1;
    #1;
    chk("s6_we", we, 0);
    chk("s6_waddr", waddr, 0);
    chk("s6_start", start_addr, 0);
    chk("s6_armed", armed, 0);
    chk("s6_done", capture_done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    wrt_smpl = 0;
    @(posedge clk);
    #1;
    check_outputs();

    // Random phase
    for (int i = 0; i < 2500; i++) begin
      if (!m_active) trig_pos = AW'($urandom);
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
